// File: rtl/sseg_display_ctrl_if.sv
// Handshake and display bus between the CPU/debug requesters and sseg_display_ctrl.
// Signal names match the original port list so existing connections carry over unchanged.
interface sseg_display_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             cpu_valid_in;
   logic [WIDTH-1:0] cpu_data_in;
   logic             cpu_ready_out;
   logic             dbg_valid_in;
   logic [WIDTH-1:0] dbg_data_in;
   logic             dbg_ready_out;
   logic [WIDTH-1:0] data_out;
   logic             src_out;

   modport master (
      output cpu_valid_in, cpu_data_in, dbg_valid_in, dbg_data_in,
      input  cpu_ready_out, dbg_ready_out, data_out, src_out
   );

   modport slave (
      input  cpu_valid_in, cpu_data_in, dbg_valid_in, dbg_data_in,
      output cpu_ready_out, dbg_ready_out, data_out, src_out
   );
endinterface

// File: rtl/sseg_display_ctrl.sv
// Seven-segment display word source: round-robin CPU/debug arbitration, with a debug word
// held on display for HOLD_CLKS clocks before the display reverts to the latest CPU word.
module sseg_display_ctrl #(
   parameter int WIDTH     = 32,
   parameter int HOLD_CLKS = 100000000
) (
   input  logic                clk_in,
   input  logic                rst_low_in,
   sseg_display_ctrl_if.slave  bus
);
   localparam int CW = $clog2(HOLD_CLKS) + 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CLKS - 1);

   typedef enum logic {SHOW_CPU, SHOW_DBG} state_t;
   typedef enum logic {GRANT_CPU, GRANT_DBG} grant_t;

   state_t           state, state_next;
   grant_t           last_grant;
   logic [CW-1:0]    hold_cnt, hold_next;
   logic [WIDTH-1:0] cpu_reg, cpu_next;
   logic [WIDTH-1:0] dbg_reg, dbg_next;
   logic [WIDTH-1:0] data_reg, data_next;
   logic             src_reg, src_next;
   logic             cpu_ready, dbg_ready;
   logic             cpu_xfer, dbg_xfer;

   // Readies are gated by the reset input so nothing is accepted while reset is asserted.
   always_comb begin
      cpu_ready = 1'b0;
      dbg_ready = 1'b0;
      if (rst_low_in) begin
         cpu_ready = bus.cpu_valid_in && (!bus.dbg_valid_in || last_grant == GRANT_DBG);
         dbg_ready = bus.dbg_valid_in && (!bus.cpu_valid_in || last_grant == GRANT_CPU);
      end
   end

   assign cpu_xfer          = cpu_ready && bus.cpu_valid_in;
   assign dbg_xfer          = dbg_ready && bus.dbg_valid_in;
   assign bus.cpu_ready_out = cpu_ready;
   assign bus.dbg_ready_out = dbg_ready;
   assign bus.data_out      = data_reg;
   assign bus.src_out       = src_reg;

   always_ff @(posedge clk_in or negedge rst_low_in) begin
      if (!rst_low_in) begin
         state    <= SHOW_CPU;
         hold_cnt <= '0;
      end else begin
         state    <= state_next;
         hold_cnt <= hold_next;
      end
   end

   always_comb begin
      state_next = state;
      hold_next  = '0;
      case (state)
         SHOW_CPU: begin
            if (dbg_xfer) state_next = SHOW_DBG;
         end
         SHOW_DBG: begin
            if (dbg_xfer) begin
               hold_next = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_next = SHOW_CPU;
            end else begin
               hold_next = hold_cnt + 1'b1;
            end
         end
         default: state_next = SHOW_CPU;
      endcase
   end

   // Display follows next-state values so an accepted word shows one cycle after its transfer.
   always_comb begin
      cpu_next  = cpu_xfer ? bus.cpu_data_in : cpu_reg;
      dbg_next  = dbg_xfer ? bus.dbg_data_in : dbg_reg;
      src_next  = (state_next == SHOW_DBG);
      data_next = src_next ? dbg_next : cpu_next;
   end

   always_ff @(posedge clk_in or negedge rst_low_in) begin
      if (!rst_low_in) begin
         cpu_reg    <= '0;
         dbg_reg    <= '0;
         data_reg   <= '0;
         src_reg    <= 1'b0;
         last_grant <= GRANT_DBG;
      end else begin
         cpu_reg  <= cpu_next;
         dbg_reg  <= dbg_next;
         data_reg <= data_next;
         src_reg  <= src_next;
         if (cpu_xfer)      last_grant <= GRANT_CPU;
         else if (dbg_xfer) last_grant <= GRANT_DBG;
      end
   end
endmodule

// File: tb/tb_sseg_display_ctrl.sv
// Directed bench for sseg_display_ctrl with a queue of expected display words.
module tb_sseg_display_ctrl;
   localparam int W = 32;
   localparam int H = 4;

   typedef struct packed {
      logic [W-1:0] d;
      logic         s;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   logic [W-1:0] m_cpu, m_dbg;
   logic         m_show_dbg, m_last_dbg;
   int           m_cnt;
   logic         g_cpu, g_dbg;

   sseg_display_ctrl_if #(.WIDTH(W)) bus ();

   sseg_display_ctrl #(.WIDTH(W), .HOLD_CLKS(H)) dut (
      .clk_in     (clk),
      .rst_low_in (rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cpu = '0;
      m_dbg = '0;
      m_show_dbg = 1'b0;
      m_last_dbg = 1'b1;
      m_cnt = 0;
      sb.delete();
   endtask

   task automatic step(input logic cv, input logic [W-1:0] cd, input logic dv, input logic [W-1:0] dd);
      logic er_c, er_d;
      exp_t e, got;
      @(negedge clk);
      bus.cpu_valid_in = cv;
      bus.cpu_data_in  = cd;
      bus.dbg_valid_in = dv;
      bus.dbg_data_in  = dd;
      #1;
      er_c = cv && (!dv || m_last_dbg);
      er_d = dv && (!cv || !m_last_dbg);
      g_cpu = bus.cpu_ready_out;
      g_dbg = bus.dbg_ready_out;
      check("cpu_ready", {31'b0, g_cpu}, {31'b0, er_c});
      check("dbg_ready", {31'b0, g_dbg}, {31'b0, er_d});
      check("one_grant", {31'b0, g_cpu & g_dbg}, '0);
      if (er_c) begin
         m_cpu = cd;
         m_last_dbg = 1'b0;
      end
      if (er_d) begin
         m_dbg = dd;
         m_last_dbg = 1'b1;
         m_show_dbg = 1'b1;
         m_cnt = 0;
      end else if (m_show_dbg) begin
         if (m_cnt == H - 1) begin
            m_show_dbg = 1'b0;
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      e.d = m_show_dbg ? m_dbg : m_cpu;
      e.s = m_show_dbg;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check("data_out", bus.data_out, got.d);
      check("src_out", {31'b0, bus.src_out}, {31'b0, got.s});
   endtask

   task automatic idle();
      step(1'b0, '0, 1'b0, '0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cpu_ready"}, {31'b0, bus.cpu_ready_out}, '0);
      check({tag, "_dbg_ready"}, {31'b0, bus.dbg_ready_out}, '0);
      check({tag, "_data"}, bus.data_out, '0);
      check({tag, "_src"}, {31'b0, bus.src_out}, '0);
   endtask

   initial begin
      logic [3:0] rr_cpu;
      rr_cpu = 4'b0101;
      model_reset();

      // Reset with both requesters valid
      bus.cpu_valid_in = 1'b1;
      bus.cpu_data_in  = 32'h1111_1111;
      bus.dbg_valid_in = 1'b1;
      bus.dbg_data_in  = 32'h2222_2222;
      rst_n = 1'b0;
      #12;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;
      bus.cpu_valid_in = 1'b0;
      bus.dbg_valid_in = 1'b0;

      // Tie right after reset: CPU, DBG, CPU, DBG
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'hC000_0000 + W'(i), 1'b1, 32'hD000_0000 + W'(i));
         check("rr_cpu_grant", {31'b0, g_cpu}, {31'b0, rr_cpu[i]});
      end
      for (int i = 0; i < 5; i++) idle();
      check("rr_revert", bus.data_out, 32'hC000_0002);

      // Fresh start, then CPU write and debug hold
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 32'h1234_5678, 1'b0, '0);
      check("cpu_write_ready", {31'b0, g_cpu}, 1);
      check("cpu_write_data", bus.data_out, 32'h1234_5678);
      step(1'b0, '0, 1'b1, 32'hDEAD_BEEF);
      check("dbg_show", bus.data_out, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) begin
         idle();
         check("dbg_hold", bus.data_out, (i < 3) ? 32'hDEAD_BEEF : 32'h1234_5678);
      end

      // CPU write during a debug hold appears only after the hold
      step(1'b0, '0, 1'b1, 32'hAAAA_0000);
      idle();
      step(1'b1, 32'h0000_0055, 1'b0, '0);
      check("hold_cpu_write", bus.data_out, 32'hAAAA_0000);
      idle();
      idle();
      check("hold_cpu_late", bus.data_out, 32'h0000_0055);

      // Hold restart at hold_cnt=2
      step(1'b0, '0, 1'b1, 32'hBBBB_0000);
      idle();
      idle();
      step(1'b0, '0, 1'b1, 32'hBBBB_0001);
      for (int i = 0; i < 4; i++) begin
         idle();
         check("restart_hold", bus.data_out, (i < 3) ? 32'hBBBB_0001 : 32'h0000_0055);
      end

      // Reset mid-hold at hold_cnt=1
      step(1'b0, '0, 1'b1, 32'hCCCC_0000);
      idle();
      #2;
      bus.cpu_valid_in = 1'b1;
      bus.dbg_valid_in = 1'b1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midhold_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      bus.cpu_valid_in = 1'b0;
      bus.dbg_valid_in = 1'b0;
      idle();
      check("post_rst_data", bus.data_out, '0);
      step(1'b0, '0, 1'b1, 32'h0000_00EE);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sseg_display_ctrl.md
SSEG_DISPLAY_CTRL -- requirements
Module: sseg_display_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, display word width in bits (4 bits per digit).
REQ-002 Parameter: HOLD_CLKS, 100000000, number of clocks a debug value stays on display (1 s at 10 ns).
REQ-003 Port: clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_low_in  input  1  reset, asynchronous, active-low.
REQ-005 Port: cpu_valid_in  input  1  CPU requester offers a display word.
REQ-006 Port: cpu_data_in  input  WIDTH  CPU display word.
REQ-007 Port: cpu_ready_out  output  1  CPU word accepted this cycle when high together with cpu_valid_in.
REQ-008 Port: dbg_valid_in  input  1  debug requester offers a display word.
REQ-009 Port: dbg_data_in  input  WIDTH  debug display word.
REQ-010 Port: dbg_ready_out  output  1  debug word accepted this cycle when high together with dbg_valid_in.
REQ-011 Port: data_out  output  WIDTH  registered word driven to the seven-segment driver data input.
REQ-012 Port: src_out  output  1  registered display source; 0 = CPU, 1 = debug.

Function
REQ-013 Transfer: occurs when valid and ready are both high in the same cycle; at most one transfer per cycle.
REQ-014 Arbitration: ready outputs are combinational from the valid inputs and last_grant; only one requester is valid -> that requester gets ready=1.
REQ-015 Arbitration, both valid: the requester not equal to last_grant gets ready=1 and the other gets ready=0 (round-robin).
REQ-016 last_grant: updates to the granted requester on every transfer; otherwise holds its value.
REQ-017 Neither valid -> both ready=0.
REQ-018 Registers: a CPU transfer loads cpu_reg; a debug transfer loads dbg_reg; both registers take effect on the next edge.
REQ-019 FSM states: SHOW_CPU, SHOW_DBG.
REQ-020 SHOW_CPU: a debug transfer -> SHOW_DBG and hold_cnt=0; otherwise the state remains SHOW_CPU.
REQ-021 SHOW_DBG, debug transfer: hold_cnt restarts at 0 and the state remains SHOW_DBG.
REQ-022 SHOW_DBG, no debug transfer, hold_cnt < HOLD_CLKS-1: hold_cnt increments.
REQ-023 SHOW_DBG, no debug transfer, hold_cnt = HOLD_CLKS-1: the state goes to SHOW_CPU and hold_cnt=0.
REQ-024 hold_cnt width: $clog2(HOLD_CLKS)+1 bits; hold_cnt never wraps.
REQ-025 CPU transfer in SHOW_DBG: updates cpu_reg only; the display and hold_cnt are unaffected.
REQ-026 data_out/src_out: registered from the next-state values, so that:
- SHOW_CPU -> data_out = next cpu_reg;
- SHOW_DBG -> data_out = next dbg_reg;
- an accepted word appears on data_out exactly 1 cycle after its transfer.
REQ-027 Revert from SHOW_DBG: data_out shows the latest cpu_reg, including any CPU writes made while the debug value was displayed.
REQ-028 Requester behaviour: the block does not require valid to be held; a dropped valid without ready is a lost request, with no error.

Reset
REQ-029 Reset assertion (asynchronous): forces cpu_reg=0, dbg_reg=0, data_out=0, src_out=0, state=SHOW_CPU, hold_cnt=0, last_grant=debug, so the CPU wins the first tie.
REQ-030 Ready outputs during reset: both are 0 while rst_low_in=0, regardless of the valid inputs.
REQ-031 Reset mid-hold: abandons SHOW_DBG immediately; after release the block starts in SHOW_CPU with data_out=0.

Verification (bench HOLD_CLKS=4)
REQ-032 Reset: pulse rst_low_in low while cpu_valid_in=1 and dbg_valid_in=1 -> ready outputs=0, data_out=0, src_out=0 during reset.
REQ-033 CPU write: cpu_valid_in=1, cpu_data_in=0x12345678 for one cycle -> cpu_ready_out=1 that cycle; next cycle data_out=0x12345678, src_out=0.
REQ-034 Debug hold: single debug transfer of 0xDEADBEEF after CPU value 0x12345678 -> data_out=0xDEADBEEF, src_out=1 for exactly 4 cycles after the transfer cycle, then data_out=0x12345678, src_out=0.
REQ-035 Tie and round-robin: both valid continuously for 4 cycles right after reset -> grants in order CPU, DBG, CPU, DBG; never both ready in one cycle.
REQ-036 CPU write during hold: debug transfer 0xAAAA0000, then CPU transfer 0x00000055 two cycles later -> data_out stays 0xAAAA0000 until the hold expires, then shows 0x00000055.
REQ-037 Hold restart and reset mid-hold:
- a second debug transfer 0xBBBB0000 at hold_cnt=2 -> the hold extends 4 more cycles;
- asserting reset at hold_cnt=1 -> data_out=0 and src_out=0 immediately.
